// File: rtl/cuckoo_insert_ctrl_if.sv
// Request/result handshake bundle between the cuckoo insert sequencer and its client.
// The slave side is the controller. The master side is the block-validation logic.
interface cuckoo_insert_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_key;
    logic              clr;
    logic              done_valid;
    logic              done_ready;
    logic [1:0]        done_status;
    logic [7:0]        done_kicks;
    logic [DATA_W-1:0] done_key;

    modport master (
        output req_valid, req_key, clr, done_ready,
        input  req_ready, done_valid, done_status, done_kicks, done_key
    );

    modport slave (
        input  req_valid, req_key, clr, done_ready,
        output req_ready, done_valid, done_status, done_kicks, done_key
    );
endinterface

// File: rtl/cuckoo_insert_ctrl.sv
// Two-table cuckoo-hash insertion sequencer: one table access per cycle, bounded evictions.
// Optional duplicate pre-check stage is enabled by defining DUP_CHECK_EN.
module cuckoo_insert_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 20,
    parameter int IDX_W     = 5,
    parameter int MAX_KICKS = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    cuckoo_insert_ctrl_if.slave bus
);

`ifdef DUP_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_CHK, S_T1, S_T2, S_RESP} state_t;
    localparam logic [1:0] ST_DUP = 2'b01;
`else
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_RESP} state_t;
`endif
    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_FAIL = 2'b10;

    state_t            r_state;
    logic [DEPTH-1:0]  r_filled1;
    logic [DEPTH-1:0]  r_filled2;
    logic [DATA_W-1:0] r_table1 [DEPTH];
    logic [DATA_W-1:0] r_table2 [DEPTH];
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_reqKey;
    logic [7:0]        r_kicks;
    logic              r_reqReady;
    logic              r_doneValid;
    logic [1:0]        r_doneStatus;
    logic [7:0]        r_doneKicks;
    logic [DATA_W-1:0] r_doneKey;

    logic [IDX_W-1:0]  w_h1;
    logic [IDX_W-1:0]  w_h2;
    logic              w_atLimit;
    logic              w_wr1;
    logic              w_wr2;

    // Hashes are defined on 32-bit wrapping arithmetic regardless of key width.
    function automatic logic [IDX_W-1:0] hash1(input logic [DATA_W-1:0] k);
        logic [31:0] k32;
        logic [31:0] c;
        k32 = 32'(k);
        c   = k32 * k32 * k32;
        return IDX_W'(c % 32'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] hash2(input logic [DATA_W-1:0] k);
        logic [31:0] k32;
        logic [31:0] s;
        k32 = 32'(k);
        s   = (k32 >= 32'd32) ? 32'd0 : (32'd1 << k32[4:0]);
        return IDX_W'((s + k32) % 32'(DEPTH));
    endfunction

    assign w_h1      = hash1(r_cur);
    assign w_h2      = hash2(r_cur);
    assign w_atLimit = (r_kicks == 8'(MAX_KICKS));
    assign w_wr1     = (r_state == S_T1) && (!r_filled1[w_h1] || !w_atLimit);
    assign w_wr2     = (r_state == S_T2) && (!r_filled2[w_h2] || !w_atLimit);

`ifdef DUP_CHECK_EN
    logic w_dup;
    assign w_dup = (r_filled1[w_h1] && (r_table1[w_h1] == r_cur)) ||
                   (r_filled2[w_h2] && (r_table2[w_h2] == r_cur));
`endif

    // Table payload is never reset; validity lives only in the filled bits.
    always_ff @(posedge clk) begin
        if (w_wr1) r_table1[w_h1] <= r_cur;
        if (w_wr2) r_table2[w_h2] <= r_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_filled1    <= '0;
            r_filled2    <= '0;
            r_cur        <= '0;
            r_reqKey     <= '0;
            r_kicks      <= '0;
            r_reqReady   <= 1'b1;
            r_doneValid  <= 1'b0;
            r_doneStatus <= ST_OK;
            r_doneKicks  <= '0;
            r_doneKey    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.clr) begin
                        r_filled1 <= '0;
                        r_filled2 <= '0;
                    end else if (bus.req_valid) begin
                        r_cur      <= bus.req_key;
                        r_reqKey   <= bus.req_key;
                        r_kicks    <= '0;
                        r_reqReady <= 1'b0;
`ifdef DUP_CHECK_EN
                        r_state    <= S_CHK;
`else
                        r_state    <= S_T1;
`endif
                    end
                end
`ifdef DUP_CHECK_EN
                S_CHK: begin
                    if (w_dup) begin
                        r_doneStatus <= ST_DUP;
                        r_doneKicks  <= '0;
                        r_doneKey    <= r_reqKey;
                        r_doneValid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_state <= S_T1;
                    end
                end
`endif
                S_T1: begin
                    if (!r_filled1[w_h1]) begin
                        r_filled1[w_h1] <= 1'b1;
                        r_doneStatus    <= ST_OK;
                        r_doneKicks     <= r_kicks;
                        r_doneKey       <= r_reqKey;
                        r_doneValid     <= 1'b1;
                        r_state         <= S_RESP;
                    end else if (w_atLimit) begin
                        r_doneStatus <= ST_FAIL;
                        r_doneKicks  <= r_kicks;
                        r_doneKey    <= r_cur;
                        r_doneValid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cur   <= r_table1[w_h1];
                        r_kicks <= r_kicks + 8'd1;
                        r_state <= S_T2;
                    end
                end
                S_T2: begin
                    if (!r_filled2[w_h2]) begin
                        r_filled2[w_h2] <= 1'b1;
                        r_doneStatus    <= ST_OK;
                        r_doneKicks     <= r_kicks;
                        r_doneKey       <= r_reqKey;
                        r_doneValid     <= 1'b1;
                        r_state         <= S_RESP;
                    end else if (w_atLimit) begin
                        r_doneStatus <= ST_FAIL;
                        r_doneKicks  <= r_kicks;
                        r_doneKey    <= r_cur;
                        r_doneValid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_cur   <= r_table2[w_h2];
                        r_kicks <= r_kicks + 8'd1;
                        r_state <= S_T1;
                    end
                end
                S_RESP: begin
                    if (bus.done_ready) begin
                        r_doneValid <= 1'b0;
                        r_reqReady  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_reqReady;
    assign bus.done_valid  = r_doneValid;
    assign bus.done_status = r_doneStatus;
    assign bus.done_kicks  = r_doneKicks;
    assign bus.done_key    = r_doneKey;

endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Directed bench for cuckoo_insert_ctrl: two instances (kick limit 16 and 0) share stimulus.
// Honours DUP_CHECK_EN: the extra check cycle shifts latencies and enables the DUP case.
module tb_cuckoo_insert_ctrl;

`ifdef DUP_CHECK_EN
    localparam int CHK_LAT = 1;
`else
    localparam int CHK_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   lat0;
    int   lat1;

    always #5 clk = ~clk;

    cuckoo_insert_ctrl_if #(.DATA_W(32)) bif0 ();
    cuckoo_insert_ctrl_if #(.DATA_W(32)) bif1 ();

    assign bif1.req_valid  = bif0.req_valid;
    assign bif1.req_key    = bif0.req_key;
    assign bif1.clr        = bif0.clr;
    assign bif1.done_ready = bif0.done_ready;

    cuckoo_insert_ctrl #(.DATA_W(32), .DEPTH(20), .IDX_W(5), .MAX_KICKS(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif0)
    );

    cuckoo_insert_ctrl #(.DATA_W(32), .DEPTH(20), .IDX_W(5), .MAX_KICKS(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Presents one key for a single cycle and waits until both instances report a result.
    task automatic applyStimulus(input logic [31:0] key);
        int cyc;
        checkOutput("reqReadyBeforeAccept", 64'(bif0.req_ready), 64'(1));
        bif0.req_key   = key;
        bif0.req_valid = 1'b1;
        lat0 = 0;
        lat1 = 0;
        cyc  = 0;
        while ((lat0 == 0 || lat1 == 0) && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            bif0.req_valid = 1'b0;
            if (lat0 == 0 && bif0.done_valid) lat0 = cyc;
            if (lat1 == 0 && bif1.done_valid) lat1 = cyc;
        end
        checkOutput("respWithinBudget", 64'(lat0 != 0 && lat1 != 0), 64'(1));
    endtask

    task automatic releaseResp();
        bif0.done_ready = 1'b1;
        @(posedge clk);
        #1;
        bif0.done_ready = 1'b0;
        checkOutput("doneDropsAfterAck", 64'(bif0.done_valid), 64'(0));
        checkOutput("readyAfterAck", 64'(bif0.req_ready), 64'(1));
    endtask

    initial begin
        rst_n           = 1'b0;
        bif0.req_valid  = 1'b0;
        bif0.req_key    = '0;
        bif0.clr        = 1'b0;
        bif0.done_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rstDoneValid", 64'(bif0.done_valid), 64'(0));
        checkOutput("rstStatus", 64'(bif0.done_status), 64'(0));
        checkOutput("rstKicks", 64'(bif0.done_kicks), 64'(0));
        checkOutput("rstKey", 64'(bif0.done_key), 64'(0));
        checkOutput("rstReqReady", 64'(bif0.req_ready), 64'(1));
        checkOutput("rstFilled1", 64'(dut0.r_filled1), 64'(0));
        checkOutput("rstFilled2", 64'(dut0.r_filled2), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // h1(14)=2744%20=4 -> direct T1 hit
        applyStimulus(32'd14);
        checkOutput("t1Latency", 64'(lat0), 64'(2 + CHK_LAT));
        checkOutput("t1Status", 64'(bif0.done_status), 64'(0));
        checkOutput("t1Kicks", 64'(bif0.done_kicks), 64'(0));
        checkOutput("t1Key", 64'(bif0.done_key), 64'(14));
        checkOutput("t1Table1At4", 64'(dut0.r_table1[4]), 64'(14));
        checkOutput("t1Filled1", 64'(dut0.r_filled1), 64'(20'h00010));
        checkOutput("t1NoKickStatus", 64'(bif1.done_status), 64'(0));
        releaseResp();

        // h1(34)=4 evicts 14, which lands in T2 at h2(14)=16398%20=18
        applyStimulus(32'd34);
        checkOutput("t2Latency", 64'(lat0), 64'(3 + CHK_LAT));
        checkOutput("t2Status", 64'(bif0.done_status), 64'(0));
        checkOutput("t2Kicks", 64'(bif0.done_kicks), 64'(1));
        checkOutput("t2Key", 64'(bif0.done_key), 64'(34));
        checkOutput("t2Table1At4", 64'(dut0.r_table1[4]), 64'(34));
        checkOutput("t2Table2At18", 64'(dut0.r_table2[18]), 64'(14));
        checkOutput("t2Filled2", 64'(dut0.r_filled2), 64'(20'h40000));
        checkOutput("t3Latency", 64'(lat1), 64'(2 + CHK_LAT));
        checkOutput("t3Status", 64'(bif1.done_status), 64'(2));
        checkOutput("t3Kicks", 64'(bif1.done_kicks), 64'(0));
        checkOutput("t3Key", 64'(bif1.done_key), 64'(34));
        checkOutput("t3Table1At4", 64'(dut1.r_table1[4]), 64'(14));
        checkOutput("t3Filled1", 64'(dut1.r_filled1), 64'(20'h00010));
        checkOutput("t3Filled2", 64'(dut1.r_filled2), 64'(0));
        releaseResp();

`ifdef DUP_CHECK_EN
        applyStimulus(32'd34);
        checkOutput("t4Latency", 64'(lat0), 64'(2));
        checkOutput("t4Status", 64'(bif0.done_status), 64'(1));
        checkOutput("t4Kicks", 64'(bif0.done_kicks), 64'(0));
        checkOutput("t4Key", 64'(bif0.done_key), 64'(34));
        checkOutput("t4Table1At4", 64'(dut0.r_table1[4]), 64'(34));
        checkOutput("t4Table2At18", 64'(dut0.r_table2[18]), 64'(14));
        checkOutput("t4Filled1", 64'(dut0.r_filled1), 64'(20'h00010));
        checkOutput("t4Filled2", 64'(dut0.r_filled2), 64'(20'h40000));
        releaseResp();
`endif

        // h1(1)=1 is free; hold the result for five cycles
        applyStimulus(32'd1);
        checkOutput("t5Latency", 64'(lat0), 64'(2 + CHK_LAT));
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5HoldValid", 64'(bif0.done_valid), 64'(1));
            checkOutput("t5HoldStatus", 64'(bif0.done_status), 64'(0));
            checkOutput("t5HoldKicks", 64'(bif0.done_kicks), 64'(0));
            checkOutput("t5HoldKey", 64'(bif0.done_key), 64'(1));
            checkOutput("t5HoldReqReady", 64'(bif0.req_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        releaseResp();

        // h1(54)=4: dut0 kicks 34 into T2; dut1 fails in T1 and sits in RESP
        bif0.req_key   = 32'd54;
        bif0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bif0.req_valid = 1'b0;
        repeat (1 + CHK_LAT) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t6MidKicks", 64'(dut0.r_kicks), 64'(1));
        checkOutput("t6MidValid0", 64'(bif0.done_valid), 64'(0));
        checkOutput("t6MidValid1", 64'(bif1.done_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("t6RstValid0", 64'(bif0.done_valid), 64'(0));
        checkOutput("t6RstValid1", 64'(bif1.done_valid), 64'(0));
        checkOutput("t6RstFilled1", 64'(dut0.r_filled1), 64'(0));
        checkOutput("t6RstFilled2", 64'(dut0.r_filled2), 64'(0));
        checkOutput("t6RstFilled1b", 64'(dut1.r_filled1), 64'(0));
        checkOutput("t6RstReqReady", 64'(bif0.req_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // h1(7)=343%20=3
        applyStimulus(32'd7);
        checkOutput("t6InsStatus", 64'(bif0.done_status), 64'(0));
        checkOutput("t6InsFilled1", 64'(dut0.r_filled1), 64'(20'h00008));
        releaseResp();

        bif0.clr       = 1'b1;
        bif0.req_valid = 1'b1;
        bif0.req_key   = 32'd9;
        @(posedge clk);
        #1;
        bif0.clr       = 1'b0;
        bif0.req_valid = 1'b0;
        checkOutput("t6ClrFilled1", 64'(dut0.r_filled1), 64'(0));
        checkOutput("t6ClrReqReady", 64'(bif0.req_ready), 64'(1));
        checkOutput("t6TableKept", 64'(dut0.r_table1[3]), 64'(7));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("t6ClrNoResp0", 64'(bif0.done_valid), 64'(0));
            checkOutput("t6ClrNoResp1", 64'(bif1.done_valid), 64'(0));
            checkOutput("t6ClrStillReady", 64'(bif0.req_ready), 64'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
